// File: rtl/mc_issuer.sv
// -----------------------------------------------------------------------------
// mc_issuer
// Initiator side of the OpRdy/ResRdy operand handshake for a multicycle unit.
// An operand pair taken from the upstream stream is presented on op0/op1 and
// announced by a single-cycle OpRdy pulse. The issuer then waits for ResRdy,
// stores res in a small result FIFO and returns to IDLE. Only one job is in
// flight at a time. If ResRdy does not arrive within TIMEOUT wait cycles, the
// job is dropped and the sticky timeout_err flag is set.
//
// Parameters
//   WIDTH      operand/result width
//   RES_DEPTH  result FIFO entries (power of 2, >= 2)
//   TIMEOUT    wait cycles allowed for ResRdy after OpRdy (>= 1)
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_a/in_b operand pair
//   OpRdy, op0, op1     issue pulse and operands to the multicycle unit
//   ResRdy, res         result pulse and result from the multicycle unit
//   out_valid/out_ready downstream handshake, out_res FIFO head
//   busy                state machine is not IDLE
//   timeout_err         sticky timeout flag, cleared only by rst
//
// Optional build macro MC_ISSUER_STATS_EN adds done_cnt (results pushed) and
// late_cnt (ResRdy seen in IDLE/ISSUE), both 16-bit wrapping counters.
// -----------------------------------------------------------------------------
module mc_issuer #(
    parameter int WIDTH     = 32,
    parameter int RES_DEPTH = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             OpRdy,
    output logic [WIDTH-1:0] op0,
    output logic [WIDTH-1:0] op1,
    input  logic             ResRdy,
    input  logic [WIDTH-1:0] res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             busy,
    output logic             timeout_err
`ifdef MC_ISSUER_STATS_EN
    ,
    output logic [15:0]      done_cnt,
    output logic [15:0]      late_cnt
`endif
);

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W  = $clog2(RES_DEPTH);
    localparam int FCNT_W = $clog2(RES_DEPTH + 1);

    // Counter value seen during wait cycle TIMEOUT (wait cycle n holds n-1).
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(RES_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic                oprdy_q,  oprdy_d;
    logic [WIDTH-1:0]    op0_q,    op0_d;
    logic [WIDTH-1:0]    op1_q,    op1_d;
    logic [CNT_W-1:0]    wcnt_q,   wcnt_d;
    logic                terr_q,   terr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q,   fcnt_d;

    logic [WIDTH-1:0]    mem [RES_DEPTH];

    logic                accept;
    logic                push;
    logic                pop;

    // Handshake decodes
    assign in_ready = (state_q == S_IDLE) && (fcnt_q < FIFO_FULL);
    assign accept   = in_valid && in_ready;
    assign push     = (state_q == S_WAIT) && ResRdy;
    assign out_valid = (fcnt_q != '0);
    assign pop      = out_valid && out_ready;

    // Next-state logic for the issue state machine
    always_comb begin
        state_d = state_q;
        oprdy_d = 1'b0;
        op0_d   = op0_q;
        op1_d   = op1_q;
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op0_d   = in_a;
                    op1_d   = in_b;
                    oprdy_d = 1'b1;  // registered pulse lines up with ISSUE
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response in the last allowed cycle still wins over timeout.
                if (ResRdy) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            oprdy_q  <= 1'b0;
            op0_q    <= '0;
            op1_q    <= '0;
            wcnt_q   <= '0;
            terr_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            oprdy_q  <= oprdy_d;
            op0_q    <= op0_d;
            op1_q    <= op1_d;
            wcnt_q   <= wcnt_d;
            terr_q   <= terr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= res;
        end
    end

    assign OpRdy       = oprdy_q;
    assign op0         = op0_q;
    assign op1         = op1_q;
    assign out_res     = mem[rd_ptr_q];
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = terr_q;

`ifdef MC_ISSUER_STATS_EN
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [15:0] late_cnt_q, late_cnt_d;

    // Both counters wrap naturally at 16 bits.
    always_comb begin
        done_cnt_d = done_cnt_q;
        late_cnt_d = late_cnt_q;
        if (push) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
        if (ResRdy && (state_q != S_WAIT)) begin
            late_cnt_d = late_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q <= '0;
            late_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
            late_cnt_q <= late_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;
    assign late_cnt = late_cnt_q;
`else
    // Statistics counters are not present in this build.
`endif

endmodule

// File: doc/mc_issuer.md
Name: mc_issuer

Overview:
Initiator side of the OpRdy/ResRdy operand handshake used by the team's multicycle multiplier.
- Accepts operand pairs from an upstream valid/ready stream and issues each one as a single-cycle OpRdy pulse.
- Waits for ResRdy and captures res into a small result FIFO drained by a downstream valid/ready stream.
- Allows one operation in flight at a time; a missing response is caught by a timeout.

Parameters:
WIDTH, 32, operand/result width
RES_DEPTH, 2, result FIFO entries (power of 2, >=2)
TIMEOUT, 15, max wait cycles for ResRdy after OpRdy (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream operand pair valid
in_ready  output  1  upstream may transfer
in_a  input  WIDTH  operand 0
in_b  input  WIDTH  operand 1
OpRdy  output  1  one-cycle issue pulse to the multicycle unit
op0  output  WIDTH  operand 0 to the unit
op1  output  WIDTH  operand 1 to the unit
ResRdy  input  1  result-valid pulse from the unit
res  input  WIDTH  result from the unit
out_valid  output  1  result FIFO non-empty
out_ready  input  1  downstream accepts head
out_res  output  WIDTH  FIFO head
busy  output  1  state != IDLE
timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE, OpRdy=0, op0=op1=0, FIFO empty (out_valid=0), timeout_err=0, wait counter=0. out_res is don't-care while empty.
- Reset mid-operation aborts the in-flight job. Any ResRdy that arrives afterwards is ignored.
- State machine: IDLE, ISSUE, WAIT.
- IDLE:
  - in_ready = (FIFO count < RES_DEPTH). Combinational, low in all other states.
  - On in_valid && in_ready: op0<=in_a, op1<=in_b, go to ISSUE.
- ISSUE:
  - OpRdy=1 for exactly this cycle (registered); op0/op1 are stable.
  - Wait counter <= 0, go to WAIT. ResRdy in this cycle is ignored.
- WAIT:
  - Counter increments each cycle; wait cycle n = nth cycle after the ISSUE cycle.
  - ResRdy in wait cycles 1..TIMEOUT: push res into the FIFO, go to IDLE.
  - No ResRdy by the end of wait cycle TIMEOUT: discard the job (no push), timeout_err<=1, go to IDLE.
- op0/op1 hold their value from acceptance until the next acceptance; they never change outside IDLE.
- ResRdy seen in IDLE or ISSUE is ignored: no push, no error.
- FIFO:
  - Push occurs only from WAIT. Pop on out_valid && out_ready.
  - Simultaneous push and pop is legal: count unchanged, order preserved.
  - Overflow cannot occur, since acceptance requires a free slot and only one job is outstanding.
  - Pop on empty has no effect.
- Latency with the multiplier (ResRdy 3 cycles after OpRdy):
  - accept edge end of cycle 0, OpRdy in cycle 1, ResRdy in cycle 4 (wait cycle 3), out_valid in cycle 5.
  - Earliest next accept is cycle 5.
- Widths: res is captured unmodified at WIDTH bits. The wait counter is $clog2(TIMEOUT+1) bits and never wraps.
- timeout_err stays set until rst. Operation continues normally after a timeout.

Optional Feature:
Macro MC_ISSUER_STATS_EN.
- Defined: adds outputs done_cnt[15:0] (results pushed) and late_cnt[15:0] (ResRdy ignored in IDLE/ISSUE).
  - Both counters reset to 0 and wrap at 16'hFFFF -> 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Basic issue: connect the multicycle multiplier; in_a=3, in_b=5, out_ready=1 -> OpRdy exactly one cycle, out_res=15 with out_valid in cycle 5 after the accept edge; busy low afterwards.
- Backpressure: out_ready=0, jobs (2,7),(4,4),(9,9) -> two results 14,16 queued in order; in_ready stays low; third job accepted only after the first pop; then 81.
- Timeout: TIMEOUT=4, stub never asserts ResRdy -> return to IDLE after wait cycle 4, timeout_err=1, FIFO empty.
  - Next job 6*6 with the real unit still returns 36.
- Late response: stub pulses ResRdy in wait cycle 5 with TIMEOUT=4 -> no push, late_cnt=1 (stats build).
  - Stray ResRdy in IDLE -> no push.
- Reset mid-WAIT: rst one cycle at wait cycle 2 -> out_valid=0, OpRdy=0, timeout_err=0, IDLE. The subsequent stub ResRdy is ignored.
- Simultaneous push/pop: FIFO holding 1 entry with out_ready=1 while ResRdy arrives -> count stays 1, outputs in issue order.
